// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory responder: runs one valid/ready transaction per load/store,
// stalls the pipeline while it is in flight and returns the aligned, extended load result.
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  input  logic [1:0]        D_CACHE_CONTROL,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              STALL,
  output logic              DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        FAULT,
  output logic              MEM_VALID,
  input  logic              MEM_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [3:0]        MEM_WSTRB,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        start;
  logic        req_store;
  logic        req_illegal;
  logic        req_misalign;
  logic [DATA_W-1:0] store_data;
  logic [3:0]  store_strb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [DATA_W-1:0] load_ext;

  // D_CACHE_CONTROL is {store,load}; both-set and neither-set are no-ops
  assign req_store = (D_CACHE_CONTROL == 2'b10);
  assign start     = REQ_VALID & ((D_CACHE_CONTROL == 2'b01) | (D_CACHE_CONTROL == 2'b10));

  assign STALL = ((state == IDLE) & start) | (state == REQ) | (state == WAIT);

  always_comb begin
    req_illegal = 1'b1;
    if (req_store) begin
      case (FUNCT3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        default:                req_illegal = 1'b1;
      endcase
    end else begin
      case (FUNCT3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                req_illegal = 1'b1;
      endcase
    end
  end

  assign req_misalign = ((FUNCT3[1:0] == 2'b01) & ADDR[0]) |
                        ((FUNCT3[1:0] == 2'b10) & (ADDR[1:0] != 2'b00));

  always_comb begin
    store_data = WDATA;
    store_strb = 4'b1111;
    case (FUNCT3[1:0])
      2'b00: begin
        store_data = {4{WDATA[7:0]}};
        store_strb = 4'b0001 << ADDR[1:0];
      end
      2'b01: begin
        store_data = {2{WDATA[15:0]}};
        store_strb = 4'b0011 << {ADDR[1], 1'b0};
      end
      default: begin
        store_data = WDATA;
        store_strb = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the byte offset captured at request time, not the live ADDR
  assign load_byte = MEM_RDATA[{addr_lo_q, 3'b000} +: 8];
  assign load_half = MEM_RDATA[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b010:  load_ext = MEM_RDATA;
      3'b100:  load_ext = {24'd0, load_byte};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      DONE       <= 1'b0;
      RDATA      <= '0;
      FAULT      <= 2'b00;
      MEM_VALID  <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WSTRB  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q <= req_store;
            funct3_q   <= FUNCT3;
            addr_lo_q  <= ADDR[1:0];
            if (req_illegal | req_misalign) begin
              // Faulting accesses never touch memory; report straight away
              FAULT <= {req_illegal, req_misalign};
              RDATA <= '0;
              DONE  <= 1'b1;
              state <= RESP;
            end else begin
              MEM_VALID <= 1'b1;
              MEM_WE    <= req_store;
              MEM_ADDR  <= {ADDR[ADDR_W-1:2], 2'b00};
              MEM_WDATA <= req_store ? store_data : '0;
              MEM_WSTRB <= req_store ? store_strb : 4'b0000;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (MEM_READY) begin
            MEM_VALID <= 1'b0;
            if (is_store_q) begin
              FAULT <= 2'b00;
              RDATA <= '0;
              DONE  <= 1'b1;
              state <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (MEM_RVALID) begin
            RDATA <= load_ext;
            FAULT <= 2'b00;
            DONE  <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, faults, back-pressure and reset in flight,
// with every expected value worked out by hand.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic [1:0]  dCacheControl;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        memValid;
  logic        memReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memRvalid;
  logic [31:0] memRdata;

  int checkCount = 0;
  int failCount  = 0;
  int doneCount;

  dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(reqValid), .D_CACHE_CONTROL(dCacheControl),
    .FUNCT3(funct3), .ADDR(addr), .WDATA(wdata), .STALL(stall), .DONE(done),
    .RDATA(rdata), .FAULT(fault), .MEM_VALID(memValid), .MEM_READY(memReady),
    .MEM_WE(memWe), .MEM_ADDR(memAddr), .MEM_WDATA(memWdata), .MEM_WSTRB(memWstrb),
    .MEM_RVALID(memRvalid), .MEM_RDATA(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge, then returns one cycle after it was sampled
  task automatic applyStimulus(input logic [1:0] ctrl, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic expStall);
    reqValid = 1'b1; dCacheControl = ctrl; funct3 = f3; addr = a; wdata = wd;
    #1;
    checkOutput("start_stall", stall, expStall);
    tick();
    reqValid = 1'b0; dCacheControl = 2'b00;
  endtask

  task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp);
    applyStimulus(2'b01, f3, a, 32'h0, 1'b1);
    checkOutput("ld_mem_valid", memValid, 1);
    checkOutput("ld_mem_we", memWe, 0);
    checkOutput("ld_mem_addr", memAddr, a & 32'hFFFF_FFFC);
    checkOutput("ld_mem_wstrb", memWstrb, 0);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checkOutput("ld_wait_valid", memValid, 0);
    checkOutput("ld_wait_stall", stall, 1);
    memRvalid = 1'b1; memRdata = rd;
    tick();
    memRvalid = 1'b0;
    checkOutput("ld_done", done, 1);
    checkOutput(tag, rdata, exp);
    checkOutput("ld_fault", fault, 0);
    checkOutput("ld_resp_stall", stall, 0);
    tick();
    checkOutput("ld_done_clear", done, 0);
  endtask

  task automatic doStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] expStrb, input logic [31:0] expData);
    applyStimulus(2'b10, f3, a, wd, 1'b1);
    checkOutput("st_mem_valid", memValid, 1);
    checkOutput("st_mem_we", memWe, 1);
    checkOutput("st_mem_addr", memAddr, a & 32'hFFFF_FFFC);
    checkOutput("st_mem_wstrb", memWstrb, expStrb);
    checkOutput("st_mem_wdata", memWdata, expData);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checkOutput("st_done", done, 1);
    checkOutput("st_rdata", rdata, 0);
    checkOutput("st_fault", fault, 0);
    checkOutput("st_mem_valid_drop", memValid, 0);
    // A request presented during the response cycle must be ignored
    reqValid = 1'b1; dCacheControl = 2'b01; funct3 = 3'b010; addr = 32'h500;
    tick();
    reqValid = 1'b0; dCacheControl = 2'b00;
    checkOutput("st_no_start_in_resp", memValid, 0);
    checkOutput("st_done_clear", done, 0);
  endtask

  task automatic doFault(input logic [2:0] f3, input logic [31:0] a, input logic [1:0] expFault);
    applyStimulus(2'b01, f3, a, 32'h0, 1'b1);
    checkOutput("flt_done", done, 1);
    checkOutput("flt_fault", fault, expFault);
    checkOutput("flt_rdata", rdata, 0);
    checkOutput("flt_no_request", memValid, 0);
    checkOutput("flt_stall", stall, 0);
    tick();
    checkOutput("flt_done_clear", done, 0);
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; dCacheControl = 2'b00; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; memReady = 1'b0; memRvalid = 1'b0; memRdata = 32'h0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mem_valid", memValid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_mem_wstrb", memWstrb, 0);
    tick();

    doLoad("lb_rdata",  3'b000, 32'h103, 32'h80AABBCC, 32'hFFFFFF80);
    doLoad("lh_rdata",  3'b001, 32'h102, 32'h80AABBCC, 32'hFFFF80AA);
    doLoad("lbu_rdata", 3'b100, 32'h101, 32'h80AABBCC, 32'h000000BB);
    doLoad("lhu_rdata", 3'b101, 32'h100, 32'h80AABBCC, 32'h0000BBCC);
    doLoad("lw_rdata",  3'b010, 32'h104, 32'h13572468, 32'h13572468);

    doStore(3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    doStore(3'b000, 32'h301, 32'h000000EF, 4'b0010, 32'hEFEFEFEF);
    doStore(3'b010, 32'h400, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    doFault(3'b010, 32'h101, 2'b01);
    doFault(3'b001, 32'h103, 2'b01);
    doFault(3'b011, 32'h000, 2'b10);

    applyStimulus(2'b11, 3'b010, 32'h0, 32'h0, 1'b0);
    checkOutput("ctl11_mem_valid", memValid, 0);
    checkOutput("ctl11_done", done, 0);
    tick();
    checkOutput("ctl11_done_later", done, 0);
    applyStimulus(2'b00, 3'b010, 32'h0, 32'h0, 1'b0);
    checkOutput("ctl00_mem_valid", memValid, 0);

    // Back-pressure: READY low for five cycles with a stray RVALID in REQ
    applyStimulus(2'b01, 3'b010, 32'h10, 32'h0, 1'b1);
    memRvalid = 1'b1; memRdata = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_mem_valid", memValid, 1);
      checkOutput("bp_mem_addr", memAddr, 32'h10);
      checkOutput("bp_stall", stall, 1);
      checkOutput("bp_done", done, 0);
      tick();
    end
    memRvalid = 1'b0;
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checkOutput("bp_wait_valid", memValid, 0);
    checkOutput("bp_wait_stall", stall, 1);
    tick();
    checkOutput("bp_wait_stall2", stall, 1);
    memRvalid = 1'b1; memRdata = 32'h11223344;
    tick();
    memRvalid = 1'b0;
    checkOutput("bp_done_pulse", done, 1);
    checkOutput("bp_rdata", rdata, 32'h11223344);
    doneCount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) doneCount++;
    end
    checkOutput("bp_single_done", doneCount, 0);

    // Reset while waiting for read data, followed by a late response
    applyStimulus(2'b01, 3'b010, 32'h20, 32'h0, 1'b1);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checkOutput("rw_stall_wait", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
    checkOutput("rw_mem_valid", memValid, 0);
    checkOutput("rw_stall", stall, 0);
    checkOutput("rw_done", done, 0);
    tick();
    memRvalid = 1'b0;
    checkOutput("rw_done_after", done, 0);
    checkOutput("rw_rdata", rdata, 0);
    checkOutput("rw_fault", fault, 0);
    checkOutput("rw_mem_addr", memAddr, 0);
    checkOutput("rw_mem_wdata", memWdata, 0);
    checkOutput("rw_mem_wstrb", memWstrb, 0);
    checkOutput("rw_mem_we", memWe, 0);
    tick();
    checkOutput("rw_done_final", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
